// File: rtl/shift_reg_universal.sv
// ---------------------------------------------------------------------------
// shift_reg_universal
//   Parametrised universal shift register: hold, shift right, shift left and
//   parallel load, with parallel/serial readout and a frame counter that
//   pulses frame_done on every WIDTH-th shift. It is the shared SIPO/PISO/SISO
//   building block for the serial links.
//
// Parameters
//   WIDTH    register length in bits (>= 2)
//   RST_VAL  value placed in the register on reset
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous reset, active-high, highest priority
//   en          in   operation enable (0 = hold everything)
//   mode        in   00 hold, 01 shift right, 10 shift left, 11 parallel load
//   sin_r       in   serial input for right shift (enters the MSB)
//   sin_l       in   serial input for left shift (enters the LSB)
//   pin         in   parallel load data
//   pout        out  register contents
//   sout_r      out  q[0], the bit leaving on a right shift
//   sout_l      out  q[WIDTH-1], the bit leaving on a left shift
//   cnt         out  shifts completed in the current frame
//   frame_done  out  one-cycle pulse when a frame of WIDTH shifts completes
// ---------------------------------------------------------------------------
module shift_reg_universal #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic                     sin_r,
  input  logic                     sin_l,
  input  logic [WIDTH-1:0]         pin,
  output logic [WIDTH-1:0]         pout,
  output logic                     sout_r,
  output logic                     sout_l,
  output logic [$clog2(WIDTH)-1:0] cnt,
  output logic                     frame_done
);

  localparam int               CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_MAX = CW'(WIDTH - 1);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_frame_done;

  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_shl;
  logic             w_last;

  // Per-bit neighbour selection for the two shift directions; the end bits
  // take the serial inputs.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bits
      if (gi == WIDTH - 1) begin : g_msb
        assign w_shr[gi] = sin_r;
      end else begin : g_shr_mid
        assign w_shr[gi] = r_q[gi+1];
      end
      if (gi == 0) begin : g_lsb
        assign w_shl[gi] = sin_l;
      end else begin : g_shl_mid
        assign w_shl[gi] = r_q[gi-1];
      end
    end
  endgenerate

  assign w_last = (r_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q          <= RST_VAL;
      r_cnt        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      // Pulse is single-cycle by default; only a frame-closing shift raises it.
      r_frame_done <= 1'b0;
      if (en) begin
        case (mode)
          MODE_SHR, MODE_SHL: begin
            r_q <= (mode == MODE_SHR) ? w_shr : w_shl;
            // Both directions advance the same frame counter.
            if (w_last) begin
              r_cnt        <= '0;
              r_frame_done <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          MODE_LOAD: begin
            r_q   <= pin;
            r_cnt <= '0;
          end
          MODE_HOLD: begin
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign pout       = r_q;
  assign sout_r     = r_q[0];
  assign sout_l     = r_q[WIDTH-1];
  assign cnt        = r_cnt;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_shift_reg_universal.sv
// ---------------------------------------------------------------------------
// tb_shift_reg_universal
//   Directed bench for shift_reg_universal (WIDTH=8, RST_VAL=0). Each task
//   drives one scenario and compares outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_shift_reg_universal;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       sin_r;
  logic       sin_l;
  logic [7:0] pin;
  logic [7:0] pout;
  logic       sout_r;
  logic       sout_l;
  logic [2:0] cnt;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  shift_reg_universal #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .sin_r      (sin_r),
    .sin_l      (sin_l),
    .pin        (pin),
    .pout       (pout),
    .sout_r     (sout_r),
    .sout_l     (sout_l),
    .cnt        (cnt),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t rst=%b en=%b mode=%b pout=%h cnt=%0d fd=%b",
             $time, rst, en, mode, pout, cnt, frame_done);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 2'b11; pin = 8'hFF; sin_r = 1'b1; sin_l = 1'b1;
    step();
    checks++;
    if (pout !== 8'h00) begin errors++; $display("FAIL reset_pout got=%h exp=00", pout); end
    checks++;
    if (cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    checks++;
    if ({sout_l, sout_r} !== 2'b00) begin errors++; $display("FAIL reset_sout got=%b exp=00", {sout_l, sout_r}); end
    rst = 1'b0;
  endtask

  task automatic test_shift_right();
    logic [7:0] bits;
    bits = 8'b0000_1101;  // bit i is the i-th serial bit sent (1,0,1,1,0,0,0,0)
    mode = 2'b01;
    for (int i = 0; i < 8; i++) begin
      sin_r = bits[i];
      step();
      checks++;
      if (frame_done !== (i == 7)) begin
        errors++; $display("FAIL shr_fd shift=%0d got=%b exp=%b", i + 1, frame_done, (i == 7));
      end
      checks++;
      if (cnt !== 3'((i + 1) % 8)) begin
        errors++; $display("FAIL shr_cnt shift=%0d got=%0d exp=%0d", i + 1, cnt, (i + 1) % 8);
      end
    end
    checks++;
    if (pout !== 8'h0D) begin errors++; $display("FAIL shr_pout got=%h exp=0D", pout); end
    mode = 2'b00;
    step();
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL shr_fd_clear got=%b exp=0", frame_done); end
  endtask

  task automatic test_piso_right();
    logic [7:0] exp_bits;
    exp_bits = 8'hA5;
    mode = 2'b11; pin = 8'hA5;
    step();
    checks++;
    if (pout !== 8'hA5 || cnt !== 3'd0) begin
      errors++; $display("FAIL load_a5 got=%h/%0d exp=A5/0", pout, cnt);
    end
    mode = 2'b01; sin_r = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sout_r !== exp_bits[i]) begin
        errors++; $display("FAIL piso_sout_r bit=%0d got=%b exp=%b", i, sout_r, exp_bits[i]);
      end
      step();
    end
    checks++;
    if (pout !== 8'h00) begin errors++; $display("FAIL piso_pout got=%h exp=00", pout); end
    checks++;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL piso_fd got=%b exp=1", frame_done); end
  endtask

  task automatic test_shift_left();
    logic [7:0] ins;
    logic [7:0] old;
    int pulses;
    ins = 8'hCA;   // MSB-first sequence 1,1,0,0,1,0,1,0
    old = 8'h3C;
    pulses = 0;
    mode = 2'b11; pin = 8'h3C;
    step();
    mode = 2'b10;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sout_l !== old[7 - i]) begin
        errors++; $display("FAIL shl_sout_l bit=%0d got=%b exp=%b", i, sout_l, old[7 - i]);
      end
      sin_l = ins[7 - i];
      step();
      if (frame_done === 1'b1) pulses++;
    end
    checks++;
    if (pout !== 8'hCA) begin errors++; $display("FAIL shl_pout got=%h exp=CA", pout); end
    checks++;
    if (pulses != 1 || frame_done !== 1'b1) begin
      errors++; $display("FAIL shl_pulses got=%0d last=%b exp=1/1", pulses, frame_done);
    end
  endtask

  task automatic test_enable_hold();
    mode = 2'b11; pin = 8'h00;
    step();
    mode = 2'b01; sin_r = 1'b1;
    for (int i = 0; i < 3; i++) step();
    // q = 1110_0000 after three 1s enter from the MSB
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mode = (i < 2) ? 2'b01 : 2'b11; pin = 8'hFF;
      step();
      checks++;
      if (cnt !== 3'd3 || pout !== 8'hE0 || frame_done !== 1'b0) begin
        errors++; $display("FAIL en0_hold cyc=%0d got=%h/%0d/%b exp=E0/3/0", i, pout, cnt, frame_done);
      end
    end
    en = 1'b1; mode = 2'b00;
    step();
    checks++;
    if (cnt !== 3'd3 || pout !== 8'hE0) begin
      errors++; $display("FAIL mode00_hold got=%h/%0d exp=E0/3", pout, cnt);
    end
    // Finish the frame with left shifts: direction change keeps counting.
    mode = 2'b10; sin_l = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (frame_done !== (i == 4)) begin
        errors++; $display("FAIL mixed_fd shift=%0d got=%b exp=%b", i + 4, frame_done, (i == 4));
      end
    end
    // E0 shifted left 5 times with 0s in -> 00
    checks++;
    if (pout !== 8'h00 || cnt !== 3'd0) begin
      errors++; $display("FAIL mixed_end got=%h/%0d exp=00/0", pout, cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q;
    mode = 2'b11; pin = 8'h00;
    step();
    mode = 2'b01; sin_r = 1'b1;
    for (int i = 0; i < 7; i++) step();
    // Reset while the next shift would have closed the frame.
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (pout !== 8'h00 || cnt !== 3'd0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL midrst got=%h/%0d/%b exp=00/0/0", pout, cnt, frame_done);
    end
    exp_q = 8'h00;
    for (int i = 1; i <= 16; i++) begin
      sin_r = i[0] ^ i[2];
      exp_q = {sin_r, exp_q[7:1]};
      step();
      checks++;
      if (frame_done !== (i == 8 || i == 16) || pout !== exp_q) begin
        errors++; $display("FAIL b2b shift=%0d got=%h/%b exp=%h/%b", i, pout, frame_done, exp_q, (i == 8 || i == 16));
      end
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; mode = 2'b00; sin_r = 1'b0; sin_l = 1'b0; pin = 8'h00;
    #2;
    test_reset();
    test_shift_right();
    test_piso_right();
    test_shift_left();
    test_enable_hold();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
